hour12_to24_setter: RTL and testbench
=====================================

// Module: hour12_to24_setter
// PURPOSE
//   Time-set controller for a clock running in 12-hour display mode. The user edits the hour as
//   01..12 BCD plus an AM/PM flag. On confirm, the block converts the edit to a 24-hour BCD hour
//   (00..23) and issues a one-cycle write strobe to the hour counter. It sits between the
//   debounced key inputs and the 24-hour hour counter's parallel-load port.
// PARAMETERS
//   TIMEOUT_CYCLES  1000  idle cycles in EDIT before the edit is abandoned with no write
//   TW              10    width of the timeout counter; must satisfy 2**TW >= TIMEOUT_CYCLES
// PORTS
//   clk          in   1  system clock; all logic on rising edge
//   rst_n        in   1  asynchronous active-low reset
//   hour_cur     in   8  current hour from the counter, 24h packed BCD, 8'h00..8'h23
//   set_req      in   1  debounced level; rising edge enters edit, or abandons an edit in progress
//   key_up       in   1  debounced level; rising edge = hour +1
//   key_down     in   1  debounced level; rising edge = hour -1
//   key_ampm     in   1  debounced level; rising edge = toggle AM/PM
//   key_ok       in   1  debounced level; rising edge = commit the edit
//   hour12_disp  out  8  hour being shown, 12h BCD, 8'h01..8'h12
//   pm_disp      out  1  1 = PM for the hour being shown
//   editing      out  1  1 while in LOAD or EDIT
//   hour24_out   out  8  committed 24h BCD hour; holds its value between commits
//   hour24_wr    out  1  one-cycle strobe; hour24_out is valid in that cycle
// BEHAVIOUR
//   Reset (async, rst_n=0)
//     - State IDLE; key edge registers 0.
//     - hour12_disp=8'h12, pm_disp=0, editing=0, hour24_out=8'h00, hour24_wr=0, timeout=0.
//   Edge detection
//     - Each key input has its own previous-value register; edge = key & ~prev.
//     - A key held high produces exactly one action.
//   State machine: IDLE -> LOAD -> EDIT -> COMMIT -> IDLE
//     - IDLE
//       - hour12_disp/pm_disp register the 12h form of hour_cur (1-cycle latency).
//       - 00 -> 12/AM; 01..11 -> same/AM; 12 -> 12/PM; 13..23 -> (h-12)/PM.
//       - set_req edge -> LOAD. All other keys are ignored.
//     - LOAD (1 cycle)
//       - Captures 12h form of hour_cur into the edit registers h12/pm.
//       - Illegal hour_cur (nibble>9 or value>8'h23) loads 12/AM.
//       - Clears timeout; goes to EDIT.
//     - EDIT, one action per cycle, priority set_req > ok > up > down > ampm
//       - set_req: abandon to IDLE; no write.
//       - ok: go to COMMIT.
//       - up: 01..10 -> BCD +1, 09->10 carries into the tens nibble; 11->12 toggles pm; 12->01.
//       - down: 12->11 toggles pm; 10->09; 01->12; others BCD -1.
//       - ampm: toggle pm.
//       - Any key edge clears timeout; otherwise timeout increments.
//       - timeout==TIMEOUT_CYCLES-1 -> IDLE; no write.
//       - hour12_disp/pm_disp show h12/pm in EDIT.
//     - COMMIT (1 cycle)
//       - hour24_out <= conv(h12,pm); hour24_wr=1 in this cycle only; then IDLE.
//       - conv: 12/AM->00; 01..11/AM->same; 12/PM->12; 01..07/PM->13..19; 08,09/PM->20,21;
//         10,11/PM->22,23.
//       - All BCD: add 12 with decimal carry; never binary arithmetic.
//   Edges in LOAD or COMMIT are discarded.
//   Reset mid-edit returns to the reset values; no write is produced.
//   hour24_wr is never asserted outside COMMIT.
// TESTING
//   1 hour_cur=8'h15, set_req pulse, ok edge -> LOAD shows 03/PM; wr one cycle, out=8'h15.
//   2 hour_cur=8'h00, set, up x1 -> disp 01/AM; ok -> out=8'h01; second up from 11 -> 12/PM.
//   3 hour_cur=8'h12 (12/PM), set, down x1 -> 11/AM; ampm -> 11/PM; ok -> out=8'h23.
//   4 hour_cur=8'h09, set, up held high 50 cycles -> only 10/AM; up+down same cycle -> up wins.
//   5 TIMEOUT_CYCLES=8: set, no keys for 8 cycles -> editing=0, hour24_wr never asserts.
//   6 rst_n low during EDIT -> outputs at reset values, wr=0; illegal hour_cur=8'h2A -> 12/AM.

Source files
------------

// File: rtl/hour12_to24_setter.sv
// ---------------------------------------------------------------------------
// hour12_to24_setter
//
// Time-set controller for a clock that displays in 12-hour mode. The user
// edits the hour as 01..12 BCD plus an AM/PM flag. On confirm, the edit is
// converted to a 24-hour BCD hour (00..23) and written to the hour counter
// with a one-cycle strobe.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   hour_cur     current 24h BCD hour from the counter (8'h00..8'h23)
//   set_req      rising edge enters edit, or abandons an edit in progress
//   key_up       rising edge: hour +1
//   key_down     rising edge: hour -1
//   key_ampm     rising edge: toggle AM/PM
//   key_ok       rising edge: commit the edit
//   hour12_disp  hour being shown, 12h BCD (8'h01..8'h12)
//   pm_disp      1 = PM for the hour being shown
//   editing      1 while loading or editing
//   hour24_out   committed 24h BCD hour, held between commits
//   hour24_wr    one-cycle write strobe, hour24_out valid in that cycle
// ---------------------------------------------------------------------------
module hour12_to24_setter #(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int TW             = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] hour_cur,
   input  logic       set_req,
   input  logic       key_up,
   input  logic       key_down,
   input  logic       key_ampm,
   input  logic       key_ok,
   output logic [7:0] hour12_disp,
   output logic       pm_disp,
   output logic       editing,
   output logic [7:0] hour24_out,
   output logic       hour24_wr
);

   localparam int NKEYS  = 5;
   localparam int K_SET  = 0;
   localparam int K_UP   = 1;
   localparam int K_DOWN = 2;
   localparam int K_AMPM = 3;
   localparam int K_OK   = 4;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EDIT, S_COMMIT} state_t;

   state_t           state_reg;
   logic [NKEYS-1:0] key_in;
   logic [NKEYS-1:0] key_prev_reg;
   logic [NKEYS-1:0] key_edge;
   logic [7:0]       h12_reg;
   logic             pm_reg;
   logic [7:0]       h12_next;
   logic             pm_next;
   logic [TW-1:0]    timeout_reg;
   logic [8:0]       cur_h12;
   logic [8:0]       up_res;
   logic [8:0]       down_res;

   assign key_in = {key_ok, key_ampm, key_down, key_up, set_req};

   // One rising-edge detector per key; a held key yields a single edge.
   generate
      for (genvar gi = 0; gi < NKEYS; gi++) begin : g_edge
         assign key_edge[gi] = key_in[gi] & ~key_prev_reg[gi];
      end
   endgenerate

   // 24h BCD -> {pm, 12h BCD}. Anything that is not a legal 00..23 BCD hour
   // shows as 12/AM, which is also what midnight maps to.
   function automatic logic [8:0] to_h12(input logic [7:0] h24);
      logic [3:0] tens;
      logic [3:0] ones;
      tens = h24[7:4];
      ones = h24[3:0];
      if (ones > 4'd9 || h24 > 8'h23) return {1'b0, 8'h12};
      if (h24 == 8'h00)               return {1'b0, 8'h12};
      if (h24 < 8'h12)                return {1'b0, h24};
      if (h24 == 8'h12)               return {1'b1, 8'h12};
      // 13..23: BCD subtract 12 with decimal borrow
      if (ones >= 4'd2)               return {1'b1, tens - 4'd1, ones - 4'd2};
      return {1'b1, tens - 4'd2, ones + 4'd8};
   endfunction

   // {12h BCD, pm} -> 24h BCD using a decimal add of 12 for PM hours.
   function automatic logic [7:0] to_h24(input logic [7:0] h12, input logic pm);
      if (!pm)                return (h12 == 8'h12) ? 8'h00 : h12;
      if (h12 == 8'h12)       return 8'h12;
      if (h12[3:0] >= 4'd8)   return {h12[7:4] + 4'd2, h12[3:0] - 4'd8};
      return {h12[7:4] + 4'd1, h12[3:0] + 4'd2};
   endfunction

   // Returns {pm_toggle, next hour}. Crossing 11<->12 flips AM/PM.
   function automatic logic [8:0] bcd_up(input logic [7:0] h12);
      if (h12 == 8'h12)      return {1'b0, 8'h01};
      if (h12 == 8'h11)      return {1'b1, 8'h12};
      if (h12[3:0] == 4'd9)  return {1'b0, h12[7:4] + 4'd1, 4'd0};
      return {1'b0, h12[7:4], h12[3:0] + 4'd1};
   endfunction

   function automatic logic [8:0] bcd_down(input logic [7:0] h12);
      if (h12 == 8'h12)      return {1'b1, 8'h11};
      if (h12 == 8'h01)      return {1'b0, 8'h12};
      if (h12[3:0] == 4'd0)  return {1'b0, h12[7:4] - 4'd1, 4'd9};
      return {1'b0, h12[7:4], h12[3:0] - 4'd1};
   endfunction

   assign cur_h12  = to_h12(hour_cur);
   assign up_res   = bcd_up(h12_reg);
   assign down_res = bcd_down(h12_reg);

   // Edit-value update for the non-exit keys, priority up > down > ampm.
   always_comb begin
      h12_next = h12_reg;
      pm_next  = pm_reg;
      if (key_edge[K_UP]) begin
         h12_next = up_res[7:0];
         pm_next  = pm_reg ^ up_res[8];
      end else if (key_edge[K_DOWN]) begin
         h12_next = down_res[7:0];
         pm_next  = pm_reg ^ down_res[8];
      end else if (key_edge[K_AMPM]) begin
         pm_next  = ~pm_reg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= S_IDLE;
         key_prev_reg <= '0;
         h12_reg      <= 8'h12;
         pm_reg       <= 1'b0;
         timeout_reg  <= '0;
         hour12_disp  <= 8'h12;
         pm_disp      <= 1'b0;
         editing      <= 1'b0;
         hour24_out   <= 8'h00;
         hour24_wr    <= 1'b0;
      end else begin
         // Previous values track every cycle, so edges arriving in LOAD or
         // COMMIT are consumed without effect.
         key_prev_reg <= key_in;
         hour24_wr    <= 1'b0;

         case (state_reg)
            S_IDLE: begin
               {pm_disp, hour12_disp} <= cur_h12;
               if (key_edge[K_SET]) begin
                  state_reg <= S_LOAD;
                  editing   <= 1'b1;
               end
            end

            S_LOAD: begin
               {pm_reg, h12_reg}      <= cur_h12;
               {pm_disp, hour12_disp} <= cur_h12;
               timeout_reg            <= '0;
               state_reg              <= S_EDIT;
            end

            S_EDIT: begin
               if (key_edge[K_SET]) begin
                  state_reg <= S_IDLE;
                  editing   <= 1'b0;
               end else if (key_edge[K_OK]) begin
                  // Strobe is raised on entry so it is high exactly while in COMMIT.
                  state_reg  <= S_COMMIT;
                  editing    <= 1'b0;
                  hour24_out <= to_h24(h12_reg, pm_reg);
                  hour24_wr  <= 1'b1;
               end else begin
                  h12_reg     <= h12_next;
                  pm_reg      <= pm_next;
                  hour12_disp <= h12_next;
                  pm_disp     <= pm_next;
               end

               if (key_edge != '0) begin
                  timeout_reg <= '0;
               end else if (timeout_reg == TW'(TIMEOUT_CYCLES - 1)) begin
                  timeout_reg <= '0;
                  state_reg   <= S_IDLE;
                  editing     <= 1'b0;
               end else begin
                  timeout_reg <= timeout_reg + 1'b1;
               end
            end

            S_COMMIT: begin
               state_reg <= S_IDLE;
            end

            default: begin
               state_reg <= S_IDLE;
               editing   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hour12_to24_setter.sv
module tb_hour12_to24_setter;

   localparam int TO = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] hour_cur = 8'h00;
   logic       set_req = 1'b0;
   logic       key_up = 1'b0;
   logic       key_down = 1'b0;
   logic       key_ampm = 1'b0;
   logic       key_ok = 1'b0;
   logic [7:0] hour12_disp;
   logic       pm_disp;
   logic       editing;
   logic [7:0] hour24_out;
   logic       hour24_wr;

   int n_cmp = 0;
   int n_fail = 0;
   int wr_seen = 0;

   hour12_to24_setter #(.TIMEOUT_CYCLES(TO), .TW(4)) dut (
      .clk(clk), .rst_n(rst_n), .hour_cur(hour_cur),
      .set_req(set_req), .key_up(key_up), .key_down(key_down),
      .key_ampm(key_ampm), .key_ok(key_ok),
      .hour12_disp(hour12_disp), .pm_disp(pm_disp), .editing(editing),
      .hour24_out(hour24_out), .hour24_wr(hour24_wr)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // The edited hour is kept as a plain integer 0..23: up/down are +-1 mod 24
   // and AM/PM is +12 mod 24; the 12h display is derived arithmetically.
   typedef enum int {M_IDLE, M_LOAD, M_EDIT, M_COMMIT} mode_t;

   function automatic int cur_val(input logic [7:0] h);
      int t;
      int o;
      t = int'(h[7:4]);
      o = int'(h[3:0]);
      if (o > 9 || t * 10 + o > 23) return 0;
      return t * 10 + o;
   endfunction

   function automatic logic [7:0] to_bcd(input int v);
      logic [7:0] r;
      r[7:4] = 4'(v / 10);
      r[3:0] = 4'(v % 10);
      return r;
   endfunction

   function automatic logic [7:0] show12(input int v);
      int h;
      h = v % 12;
      if (h == 0) h = 12;
      return to_bcd(h);
   endfunction

   function automatic int step(input int h, input logic [4:0] e);
      if (e[1]) return (h + 1) % 24;
      if (e[2]) return (h + 23) % 24;
      if (e[3]) return (h + 12) % 24;
      return h;
   endfunction

   wire [4:0] keys = {key_ok, key_ampm, key_down, key_up, set_req};
   logic [4:0] m_prev;
   wire  [4:0] m_edge = keys & ~m_prev;
   mode_t      m_mode;
   int         m_hour;
   int         m_show;
   int         m_idle;
   logic [7:0] m_out;
   logic       m_wr;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode <= M_IDLE;
         m_prev <= '0;
         m_hour <= 0;
         m_show <= 0;
         m_idle <= 0;
         m_out  <= 8'h00;
         m_wr   <= 1'b0;
      end else begin
         m_prev <= keys;
         m_wr   <= 1'b0;
         case (m_mode)
            M_IDLE: begin
               m_show <= cur_val(hour_cur);
               if (m_edge[0]) m_mode <= M_LOAD;
            end
            M_LOAD: begin
               m_hour <= cur_val(hour_cur);
               m_show <= cur_val(hour_cur);
               m_idle <= 0;
               m_mode <= M_EDIT;
            end
            M_EDIT: begin
               if (m_edge[0]) begin
                  m_mode <= M_IDLE;
               end else if (m_edge[4]) begin
                  m_mode <= M_COMMIT;
                  m_wr   <= 1'b1;
                  m_out  <= to_bcd(m_hour);
               end else begin
                  m_hour <= step(m_hour, m_edge);
                  m_show <= step(m_hour, m_edge);
               end
               if (m_edge != '0) begin
                  m_idle <= 0;
               end else if (m_idle == TO - 1) begin
                  m_idle <= 0;
                  m_mode <= M_IDLE;
               end else begin
                  m_idle <= m_idle + 1;
               end
            end
            default: m_mode <= M_IDLE;
         endcase
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("disp", hour12_disp, show12(m_show));
      chk("pm", {7'b0, pm_disp}, {7'b0, (m_show >= 12)});
      chk("editing", {7'b0, editing}, {7'b0, (m_mode == M_LOAD || m_mode == M_EDIT)});
      chk("out", hour24_out, m_out);
      chk("wr", {7'b0, hour24_wr}, {7'b0, m_wr});
      if (hour24_wr) wr_seen++;
   end

   // ---------------- stimulus ----------------
   localparam int K_SET = 0, K_UP = 1, K_DOWN = 2, K_AMPM = 3, K_OK = 4;

   task automatic drive(input int k, input logic v);
      case (k)
         K_SET:  set_req  = v;
         K_UP:   key_up   = v;
         K_DOWN: key_down = v;
         K_AMPM: key_ampm = v;
         default: key_ok  = v;
      endcase
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int k);
      drive(k, 1'b1);
      @(negedge clk);
      drive(k, 1'b0);
   endtask

   task automatic enter_edit(input logic [7:0] h);
      hour_cur = h;
      cycles(2);
      press(K_SET);
      cycles(1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      cycles(3);
      chk("lit_reset_disp", hour12_disp, 8'h12);
      chk("lit_reset_out", hour24_out, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      cycles(2);

      // 1: 15 -> 03/PM, commit writes 15
      enter_edit(8'h15);
      chk("lit_t1_disp", hour12_disp, 8'h03);
      chk("lit_t1_pm", {7'b0, pm_disp}, 8'h01);
      chk("lit_t1_edit", {7'b0, editing}, 8'h01);
      press(K_OK);
      chk("lit_t1_wr", {7'b0, hour24_wr}, 8'h01);
      chk("lit_t1_out", hour24_out, 8'h15);
      cycles(1);
      chk("lit_t1_wr_low", {7'b0, hour24_wr}, 8'h00);
      $display("test1: hour_cur=15 commit out=%h", hour24_out);

      // 2: 00 up -> 01/AM, commit 01; 11 up -> 12/PM then abandon
      enter_edit(8'h00);
      press(K_UP);
      chk("lit_t2_disp", hour12_disp, 8'h01);
      chk("lit_t2_pm", {7'b0, pm_disp}, 8'h00);
      press(K_OK);
      chk("lit_t2_out", hour24_out, 8'h01);
      cycles(1);
      enter_edit(8'h11);
      press(K_UP);
      chk("lit_t2_disp12", hour12_disp, 8'h12);
      chk("lit_t2_pm12", {7'b0, pm_disp}, 8'h01);
      press(K_SET);
      cycles(1);
      chk("lit_t2_abandon_out", hour24_out, 8'h01);
      $display("test2: up from 00 and 11, out=%h", hour24_out);

      // 3: 12/PM down -> 11/AM, ampm -> 11/PM, commit 23
      enter_edit(8'h12);
      press(K_DOWN);
      chk("lit_t3_disp", hour12_disp, 8'h11);
      chk("lit_t3_pm_am", {7'b0, pm_disp}, 8'h00);
      press(K_AMPM);
      chk("lit_t3_pm_pm", {7'b0, pm_disp}, 8'h01);
      press(K_OK);
      chk("lit_t3_out", hour24_out, 8'h23);
      cycles(1);
      $display("test3: 12PM down ampm commit out=%h", hour24_out);

      // 4: held up gives one step; up+down together -> up wins
      enter_edit(8'h09);
      key_up = 1'b1;
      cycles(5);
      chk("lit_t4_held", hour12_disp, 8'h10);
      cycles(45);
      key_up = 1'b0;
      enter_edit(8'h09);
      key_up = 1'b1;
      key_down = 1'b1;
      cycles(1);
      key_up = 1'b0;
      key_down = 1'b0;
      chk("lit_t4_updown", hour12_disp, 8'h10);
      press(K_OK);
      chk("lit_t4_out", hour24_out, 8'h10);
      cycles(1);
      $display("test4: held key and simultaneous keys, out=%h", hour24_out);

      // 5: timeout after TO idle cycles in EDIT, no write
      hour_cur = 8'h07;
      cycles(2);
      wr_seen = 0;
      press(K_SET);
      cycles(TO);
      chk("lit_t5_still_edit", {7'b0, editing}, 8'h01);
      cycles(1);
      chk("lit_t5_timeout", {7'b0, editing}, 8'h00);
      cycles(3);
      chk("lit_t5_no_wr", 8'(wr_seen), 8'h00);
      $display("test5: timeout, writes seen=%0d", wr_seen);

      // 6: async reset mid-edit, then illegal hour loads 12/AM
      enter_edit(8'h05);
      press(K_UP);
      #2 rst_n = 1'b0;
      @(negedge clk);
      chk("lit_t6_disp", hour12_disp, 8'h12);
      chk("lit_t6_edit", {7'b0, editing}, 8'h00);
      chk("lit_t6_out", hour24_out, 8'h00);
      chk("lit_t6_wr", {7'b0, hour24_wr}, 8'h00);
      rst_n = 1'b1;
      cycles(1);
      enter_edit(8'h2A);
      chk("lit_t6_illegal", hour12_disp, 8'h12);
      chk("lit_t6_illegal_pm", {7'b0, pm_disp}, 8'h00);
      press(K_UP);
      press(K_OK);
      chk("lit_t6_out01", hour24_out, 8'h01);
      cycles(2);
      $display("test6: reset mid-edit and illegal hour, out=%h", hour24_out);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
